// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a_in - b_in - bin, LSB first) around one full-subtractor cell.
// Optional signed-overflow output ovf is compiled in when SERSUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SERSUB_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d_s, cell_bo_s;
`ifdef SERSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell fed from the operand LSBs and the running borrow.
  always_comb begin
    cell_d_s  = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    cell_bo_s = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & brw_q) | (b_sr_q[0] & brw_q);
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          brw_d   = bin;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_sr_d = {cell_d_s, res_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        brw_d    = cell_bo_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          diff_d   = {cell_d_s, res_sr_q[WIDTH-1:1]};
          borrow_d = cell_bo_s;
`ifdef SERSUB_OVF_EN
          // On the last bit the shift registers hold the captured operand MSBs.
          ovf_d    = (a_sr_q[0] != b_sr_q[0]) && (cell_d_s != a_sr_q[0]);
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      res_sr_q <= {WIDTH{1'b0}};
      brw_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERSUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); ovf checks compile in with SERSUB_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bin = 1'b0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff_out;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [9:0] sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .bin(bin),
    .busy(busy), .done(done), .diff_out(diff_out), .borrow_out(borrow_out)
`ifdef SERSUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected {ovf, borrow, diff} from plain unsigned arithmetic.
  function automatic logic [9:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] full;
    logic       v;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    v    = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return {v, full};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      logic [9:0] e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("diff", {24'd0, diff_out}, {24'd0, e[7:0]});
        check("borrow", {31'd0, borrow_out}, {31'd0, e[8]});
`ifdef SERSUB_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e[9]});
`endif
      end
    end
  end

  // Called at posedge+1; optionally pulses a spurious start on cycle 3.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit inject);
    int n;
    int d0;
    d0 = done_cnt;
    a_in = a; b_in = b; bin = bi; start = 1'b1;
    sb.push_back(model(a, b, bi));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_e0", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 3) begin
        start = 1'b1; a_in = 8'h11; b_in = 8'h22; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("latency", n, 32'd8);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_pulses", done_cnt - d0, 32'd1);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int m;
    int d0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff_out}, 32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERSUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(posedge clk); #1;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    do_op(8'h7F, 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Spurious start mid-operation must be ignored.
    do_op(8'hC3, 8'h5D, 1'b0, 1'b1);
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1 check("no_extra_done", done_cnt - d0, 32'd0);

    // Reset mid-operation discards the in-flight result.
    a_in = 8'h9E; b_in = 8'h21; bin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h9E, 8'h21, 1'b0));
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff_out}, 32'd0);
    check("midrst_borrow", {31'd0, borrow_out}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1 check("midrst_no_done", done_cnt - d0, 32'd0);
    do_op(8'h33, 8'h44, 1'b1, 1'b0);

    // Start held through DONE: back-to-back operations.
    d0 = done_cnt;
    a_in = 8'h5A; b_in = 8'h3C; bin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h5A, 8'h3C, 1'b0));
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
    end while (!done && m < 30);
    check("b2b_first_latency", m, 32'd9);
    a_in = 8'h10; b_in = 8'h20; bin = 1'b1;
    sb.push_back(model(8'h10, 8'h20, 1'b1));
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
      start = 1'b0;
    end while (!done && m < 30);
    check("b2b_spacing", m, 32'd9);
    @(posedge clk); #1;
    check("b2b_done_pulses", done_cnt - d0, 32'd2);
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
